// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and frame map for the two-player sprite sequencer.
package sprite_pkg;

  localparam int FRAME_W    = 60;
  localparam int FRAME_H    = 70;
  localparam int FRAME_SIZE = 4200;

  typedef enum logic [1:0] {
    ST_STAND  = 2'd0,
    ST_WALK   = 2'd1,
    ST_JUMP   = 2'd2,
    ST_ATTACK = 2'd3
  } anim_state_t;

  localparam logic [1:0] CMD_STAND  = 2'd0;
  localparam logic [1:0] CMD_WALK   = 2'd1;
  localparam logic [1:0] CMD_JUMP   = 2'd2;
  localparam logic [1:0] CMD_ATTACK = 2'd3;

  localparam logic [4:0] STAND_FIRST  = 5'd0;
  localparam logic [4:0] STAND_LAST   = 5'd0;
  localparam logic [4:0] WALK_FIRST   = 5'd1;
  localparam logic [4:0] WALK_LAST    = 5'd8;
  localparam logic [4:0] JUMP_FIRST   = 5'd9;
  localparam logic [4:0] JUMP_LAST    = 5'd12;
  localparam logic [4:0] ATTACK_FIRST = 5'd13;
  localparam logic [4:0] ATTACK_LAST  = 5'd17;

  function automatic anim_state_t cmd_to_state(input logic [1:0] cmd);
    anim_state_t st;
    case (cmd)
      CMD_WALK:   st = ST_WALK;
      CMD_JUMP:   st = ST_JUMP;
      CMD_ATTACK: st = ST_ATTACK;
      default:    st = ST_STAND;
    endcase
    return st;
  endfunction

  function automatic logic [4:0] first_frame(input anim_state_t st);
    logic [4:0] f;
    case (st)
      ST_WALK:   f = WALK_FIRST;
      ST_JUMP:   f = JUMP_FIRST;
      ST_ATTACK: f = ATTACK_FIRST;
      default:   f = STAND_FIRST;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sprite_anim_fsm.sv
// Per-player animation FSM: state, hold counter and frame index, all stepped only on frame_tick.
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int HOLD_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [1:0]  cmd,
  output anim_state_t state,
  output logic [4:0]  frame_idx
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  anim_state_t       state_q, state_d;
  logic [4:0]        frame_q, frame_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  anim_state_t       req_state;
  logic              hold_done;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    hold_d    = hold_q;
    req_state = cmd_to_state(cmd);
    hold_done = (hold_q == HOLD_LAST);
    if (frame_tick) begin
      if (state_q == ST_ATTACK) begin
        // Attack ignores cmd until the last frame has been shown for its full hold.
        if (hold_done) begin
          hold_d = '0;
          if (frame_q == ATTACK_LAST) begin
            state_d = req_state;
            frame_d = first_frame(req_state);
          end else begin
            frame_d = frame_q + 5'd1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end else if (req_state != state_q) begin
        state_d = req_state;
        frame_d = first_frame(req_state);
        hold_d  = '0;
      end else if (hold_done) begin
        hold_d = '0;
        case (state_q)
          ST_WALK: frame_d = (frame_q == WALK_LAST) ? WALK_FIRST : frame_q + 5'd1;
          ST_JUMP: frame_d = (frame_q == JUMP_LAST) ? JUMP_LAST : frame_q + 5'd1;
          default: frame_d = STAND_LAST;
        endcase
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STAND;
      frame_q <= STAND_FIRST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
    end
  end

  assign state     = state_q;
  assign frame_idx = frame_q;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Two-player sprite sequencer: per-player animation FSMs plus pixel-to-ROM address
// generation, with in_sprite delayed to line up with the ROM's registered read data.
module sprite_anim_sequencer
  import sprite_pkg::*;
#(
  parameter int HOLD_TICKS = 4,
  parameter int ADDR_W     = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [1:0]        cmd1,
  input  logic [1:0]        cmd2,
  input  logic              face_left1,
  input  logic              face_left2,
  input  logic [9:0]        pos_x1,
  input  logic [9:0]        pos_y1,
  input  logic [9:0]        pos_x2,
  input  logic [9:0]        pos_y2,
  output logic [ADDR_W-1:0] read_address1,
  output logic [ADDR_W-1:0] read_address2,
  output logic              in_sprite1,
  output logic              in_sprite2,
  output logic [4:0]        frame_idx1,
  output logic [4:0]        frame_idx2,
  output logic              busy1,
  output logic              busy2
);

  anim_state_t state1, state2;

  sprite_anim_fsm #(.HOLD_TICKS(HOLD_TICKS)) u_fsm1 (
    .clk        (Clk),
    .reset      (Reset),
    .frame_tick (frame_tick),
    .cmd        (cmd1),
    .state      (state1),
    .frame_idx  (frame_idx1)
  );

  sprite_anim_fsm #(.HOLD_TICKS(HOLD_TICKS)) u_fsm2 (
    .clk        (Clk),
    .reset      (Reset),
    .frame_tick (frame_tick),
    .cmd        (cmd2),
    .state      (state2),
    .frame_idx  (frame_idx2)
  );

  assign busy1 = (state1 == ST_ATTACK);
  assign busy2 = (state2 == ST_ATTACK);

  // Returns {hit, addr}; addr is forced to 0 outside the sprite box. The DrawX >= pos_x
  // term stops the 10-bit subtraction from wrapping a right-edge sprite into column 0.
  function automatic logic [ADDR_W:0] pix_lookup(
    input logic [9:0] dx,
    input logic [9:0] dy,
    input logic [9:0] px,
    input logic [9:0] py,
    input logic       fl,
    input logic [4:0] frame
  );
    logic [9:0]        rel_x;
    logic [9:0]        rel_y;
    logic [9:0]        col;
    logic              hit;
    logic [ADDR_W-1:0] addr;
    rel_x = dx - px;
    rel_y = dy - py;
    hit   = (dx >= px) && (rel_x < 10'(FRAME_W)) && (dy >= py) && (rel_y < 10'(FRAME_H));
    col   = fl ? (10'(FRAME_W - 1) - rel_x) : rel_x;
    addr  = ADDR_W'(frame) * ADDR_W'(FRAME_SIZE) + ADDR_W'(rel_y) * ADDR_W'(FRAME_W)
          + ADDR_W'(col);
    return {hit, hit ? addr : '0};
  endfunction

  logic [ADDR_W-1:0] read_address1_q, read_address1_d;
  logic [ADDR_W-1:0] read_address2_q, read_address2_d;
  logic              hit1_q, hit1_d, hit2_q, hit2_d;
  logic              in_sprite1_q, in_sprite2_q;

  always_comb begin
    {hit1_d, read_address1_d} = pix_lookup(DrawX, DrawY, pos_x1, pos_y1, face_left1, frame_idx1);
    {hit2_d, read_address2_d} = pix_lookup(DrawX, DrawY, pos_x2, pos_y2, face_left2, frame_idx2);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address1_q <= '0;
      read_address2_q <= '0;
      hit1_q          <= 1'b0;
      hit2_q          <= 1'b0;
      in_sprite1_q    <= 1'b0;
      in_sprite2_q    <= 1'b0;
    end else begin
      read_address1_q <= read_address1_d;
      read_address2_q <= read_address2_d;
      hit1_q          <= hit1_d;
      hit2_q          <= hit2_d;
      in_sprite1_q    <= hit1_q;
      in_sprite2_q    <= hit2_q;
    end
  end

  assign read_address1 = read_address1_q;
  assign read_address2 = read_address2_q;
  assign in_sprite1    = in_sprite1_q;
  assign in_sprite2    = in_sprite2_q;

endmodule
